unidade_controle_genius: RTL and testbench

Moore FSM that sequences the memory-game datapath: address counter, round counter, play register, jogada timer and sync RAM. Consumes datapath status (igual, endIgualRod, fimRod, fimT, jogada_feita). Drives every zera/conta/registra strobe. Reports game outcome to the top level.

---
 rtl/unidade_controle_genius_pkg.sv | 46 ++++
 rtl/unidade_controle_genius.sv | 115 +++++++++++
 tb/tb_unidade_controle_genius.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/unidade_controle_genius_pkg.sv
// unidade_controle_genius_pkg: state codes, debug width default and hex helper for the memory-game control unit
package unidade_controle_genius_pkg;

    localparam int W_ESTADO_DEF = 5;

    localparam logic [3:0] cod_fim_acertou = 4'hA;
    localparam logic [3:0] cod_fim_errou   = 4'hE;
    localparam logic [3:0] cod_fim_timeout = 4'hD;

    typedef enum logic [3:0] {
        inicial          = 4'h0,
        preparacao       = 4'h1,
        inicia_rodada    = 4'h2,
        espera_jogada    = 4'h3,
        registra         = 4'h4,
        comparacao       = 4'h5,
        proximo_endereco = 4'h6,
        proxima_rodada   = 4'h7,
        fim_acertou      = cod_fim_acertou,
        fim_errou        = cod_fim_errou,
        fim_timeout      = cod_fim_timeout
    } estado_t;

    // Active-low seven-segment pattern {g,f,e,d,c,b,a} for a state code
    function automatic logic [6:0] estado_para_hex(input logic [3:0] e);
        case (e)
            4'h0: estado_para_hex = 7'b1000000;
            4'h1: estado_para_hex = 7'b1111001;
            4'h2: estado_para_hex = 7'b0100100;
            4'h3: estado_para_hex = 7'b0110000;
            4'h4: estado_para_hex = 7'b0011001;
            4'h5: estado_para_hex = 7'b0010010;
            4'h6: estado_para_hex = 7'b0000010;
            4'h7: estado_para_hex = 7'b1111000;
            4'h8: estado_para_hex = 7'b0000000;
            4'h9: estado_para_hex = 7'b0010000;
            4'hA: estado_para_hex = 7'b0001000;
            4'hB: estado_para_hex = 7'b0000011;
            4'hC: estado_para_hex = 7'b1000110;
            4'hD: estado_para_hex = 7'b0100001;
            4'hE: estado_para_hex = 7'b0000110;
            default: estado_para_hex = 7'b0001110;
        endcase
    endfunction

endpackage

// File: rtl/unidade_controle_genius.sv
// unidade_controle_genius: Moore FSM sequencing the memory-game datapath; define TIMEOUT_EN to enable the play timer
module unidade_controle_genius
    import unidade_controle_genius_pkg::*;
#(
    parameter int W_ESTADO = W_ESTADO_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                igual,
    input  logic                endIgualRod,
    input  logic                fimRod,
    input  logic                fimT,
    input  logic                jogada_feita,
    output logic                zeraE,
    output logic                contaE,
    output logic                zeraRod,
    output logic                contaRod,
    output logic                zeraT,
    output logic                contaT,
    output logic                zeraR,
    output logic                registraR,
    output logic                pronto,
    output logic                acertou,
    output logic                errou,
    output logic                timeout,
    output logic [W_ESTADO-1:0] db_estado
);

`ifdef TIMEOUT_EN
    localparam bit timeout_en = 1'b1;
`else
    localparam bit timeout_en = 1'b0;
`endif

    estado_t estado, proximo;

    // State register, cleared to inicial asynchronously by reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= inicial;
        else        estado <= proximo;
    end

    // Next state and Moore outputs; a play beats a simultaneous timer expiry
    always_comb begin
        proximo   = inicial;
        zeraE     = 1'b0;
        contaE    = 1'b0;
        zeraRod   = 1'b0;
        contaRod  = 1'b0;
        zeraT     = 1'b0;
        contaT    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        case (estado)
            inicial: proximo = iniciar ? preparacao : inicial;
            preparacao: begin
                zeraE   = 1'b1;
                zeraRod = 1'b1;
                zeraR   = 1'b1;
                zeraT   = 1'b1;
                proximo = inicia_rodada;
            end
            inicia_rodada: begin
                zeraE   = 1'b1;
                zeraT   = 1'b1;
                proximo = espera_jogada;
            end
            espera_jogada: begin
                contaT  = timeout_en;
                proximo = jogada_feita ? registra :
                          (timeout_en && fimT) ? fim_timeout : espera_jogada;
            end
            registra: begin
                registraR = 1'b1;
                zeraT     = 1'b1;
                proximo   = comparacao;
            end
            comparacao: proximo = !igual ? fim_errou :
                                  (endIgualRod && fimRod) ? fim_acertou :
                                  endIgualRod ? proxima_rodada : proximo_endereco;
            proximo_endereco: begin
                contaE  = 1'b1;
                proximo = espera_jogada;
            end
            proxima_rodada: begin
                contaRod = 1'b1;
                proximo  = inicia_rodada;
            end
            fim_acertou: begin
                pronto  = 1'b1;
                acertou = 1'b1;
                proximo = iniciar ? preparacao : fim_acertou;
            end
            fim_errou: begin
                pronto  = 1'b1;
                errou   = 1'b1;
                proximo = iniciar ? preparacao : fim_errou;
            end
            fim_timeout: begin
                pronto  = 1'b1;
                timeout = timeout_en;
                proximo = iniciar ? preparacao : fim_timeout;
            end
            default: proximo = inicial;
        endcase
    end

    assign db_estado = W_ESTADO'(estado);

endmodule

// File: tb/tb_unidade_controle_genius.sv
// tb_unidade_controle_genius: scripted random games checked cycle by cycle against expected state trace
module tb_unidade_controle_genius;

`ifdef TIMEOUT_EN
    localparam bit ten = 1'b1;
`else
    localparam bit ten = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset, iniciar, igual, endIgualRod, fimRod, fimT, jogada_feita;
    logic zeraE, contaE, zeraRod, contaRod, zeraT, contaT, zeraR, registraR;
    logic pronto, acertou, errou, timeout;
    logic [4:0] db_estado;
    logic [11:0] outs;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] code;
        bit ini, ig, eir, fr, jf, ft, rm;
    } entry_t;

    entry_t script[$];

    unidade_controle_genius dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .igual(igual),
        .endIgualRod(endIgualRod), .fimRod(fimRod), .fimT(fimT),
        .jogada_feita(jogada_feita), .zeraE(zeraE), .contaE(contaE),
        .zeraRod(zeraRod), .contaRod(contaRod), .zeraT(zeraT), .contaT(contaT),
        .zeraR(zeraR), .registraR(registraR), .pronto(pronto), .acertou(acertou),
        .errou(errou), .timeout(timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    assign outs = {zeraE, contaE, zeraRod, contaRod, zeraT, contaT,
                   zeraR, registraR, pronto, acertou, errou, timeout};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Strobes the game table demands in each phase, ordered as outs
    function automatic logic [11:0] exp_out(input logic [3:0] c);
        case (c)
            4'h1: return 12'b1010_1010_0000;
            4'h2: return 12'b1000_1000_0000;
            4'h3: return ten ? 12'b0000_0100_0000 : 12'b0;
            4'h4: return 12'b0000_1001_0000;
            4'h6: return 12'b0100_0000_0000;
            4'h7: return 12'b0001_0000_0000;
            4'hA: return 12'b0000_0000_1100;
            4'hE: return 12'b0000_0000_1010;
            4'hD: return ten ? 12'b0000_0000_1001 : 12'b0000_0000_1000;
            default: return 12'b0;
        endcase
    endfunction

    function automatic bit pick(input int v);
        return (v == 2) ? bit'($urandom_range(0, 1)) : bit'(v);
    endfunction

    task automatic push(input logic [3:0] c, input int ini, input int ig, input int eir,
                        input int fr, input int jf, input int ft, input bit rm = 1'b0);
        entry_t e;
        e.code = c;
        e.ini = pick(ini);
        e.ig = pick(ig);
        e.eir = pick(eir);
        e.fr = pick(fr);
        e.jf = pick(jf);
        e.ft = pick(ft);
        e.rm = rm;
        script.push_back(e);
    endtask

    // One game of n rounds: kind 0 win, 1 wrong play at (pr,pa), 2 timer expiry at (pr,pa)
    task automatic add_game(input int n, input int kind, input int pr, input int pa);
        logic [3:0] fim = 4'h0;
        push(4'h1, 2, 2, 2, 2, 2, 2);
        for (int r = 0; r < n && fim == 4'h0; r++) begin
            push(4'h2, 2, 2, 2, 2, 2, 2);
            for (int a = 0; a <= r && fim == 4'h0; a++) begin
                int w = $urandom_range(0, 3);
                repeat (w) push(4'h3, 2, 2, 2, 2, 0, ten ? 0 : 2);
                if (kind == 2 && r == pr && a == pa) begin
                    push(4'h3, 2, 2, 2, 2, 0, 1);
                    if (ten) begin
                        fim = 4'hD;
                        break;
                    end
                end
                push(4'h3, 2, 2, 2, 2, 1, 2);
                push(4'h4, 2, 2, 2, 2, 2, 2);
                if (kind == 1 && r == pr && a == pa) begin
                    push(4'h5, 2, 0, 2, 2, 2, 2);
                    fim = 4'hE;
                end else if (a == r && r == n - 1) begin
                    push(4'h5, 2, 1, 1, 1, 2, 2);
                    fim = 4'hA;
                end else if (a == r) begin
                    push(4'h5, 2, 1, 1, 0, 2, 2);
                    push(4'h7, 2, 2, 2, 2, 2, 2);
                end else begin
                    push(4'h5, 2, 1, 0, 2, 2, 2);
                    push(4'h6, 2, 2, 2, 2, 2, 2);
                end
            end
        end
        push(fim, 0, 2, 2, 2, 2, 2);
        push(fim, 0, 2, 2, 2, 2, 2);
        push(fim, 1, 2, 2, 2, 2, 2);
    endtask

    initial begin
        reset = 1'b0;
        {iniciar, igual, endIgualRod, fimRod, fimT, jogada_feita} = '0;
        #2;
        check("reset_estado", 32'(db_estado), 32'h0);
        check("reset_saidas", 32'(outs), 32'h0);
        #1 reset = 1'b1;
        push(4'h0, 0, 2, 2, 2, 2, 2);
        push(4'h0, 1, 2, 2, 2, 2, 2);
        add_game(16, 0, 0, 0);
        add_game(3, 1, 1, int'($urandom_range(0, 1)));
        add_game(4, 2, 2, 1);
        for (int g = 0; g < 4; g++) begin
            int n = $urandom_range(1, 6);
            int pr = $urandom_range(0, n - 1);
            add_game(n, $urandom_range(0, 2), pr, $urandom_range(0, pr));
        end
        push(4'h1, 2, 2, 2, 2, 2, 2);
        push(4'h2, 2, 2, 2, 2, 2, 2);
        push(4'h3, 2, 2, 2, 2, 1, 2);
        push(4'h4, 2, 2, 2, 2, 2, 2);
        push(4'h5, 2, 1, 0, 2, 2, 2);
        push(4'h6, 0, 2, 2, 2, 2, 2, 1'b1);
        push(4'h0, 0, 2, 2, 2, 2, 2);
        push(4'h0, 1, 2, 2, 2, 2, 2);
        push(4'h1, 2, 2, 2, 2, 2, 2);
        push(4'h2, 2, 2, 2, 2, 2, 2);
        foreach (script[i]) begin
            entry_t e = script[i];
            check($sformatf("estado[%0d]", i), 32'(db_estado), 32'(e.code));
            check($sformatf("saidas[%0d]", i), 32'(outs), 32'(exp_out(e.code)));
            {iniciar, igual, endIgualRod, fimRod, jogada_feita, fimT} =
                {e.ini, e.ig, e.eir, e.fr, e.jf, e.ft};
            if (e.rm) begin
                reset = 1'b0;
                #1;
                check("reset_meio_estado", 32'(db_estado), 32'h0);
                check("reset_meio_saidas", 32'(outs), 32'h0);
                #1 reset = 1'b1;
            end
            @(posedge clock);
            #1;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
